// File: rtl/mem_init_pkg.sv
// Shared state encoding and default sizing for the boot-time memory image copier.
// MEM_INIT_VERIFY_EN adds the readback states.
package mem_init_pkg;

  localparam int AW_DEF     = 15;
  localparam int SETTLE_DEF = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FETCH,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
`ifdef MEM_INIT_VERIFY_EN
    , ST_VFETCH,
    ST_VREAD,
    ST_VNEXT
`endif
  } state_t;

endpackage

// File: rtl/ce_delay.sv
// Clock-enable gated down-counter: counts N ce ticks while i_run is high and
// pulses o_tc on the last one; reloads whenever i_run is low.
module ce_delay #(
  parameter int N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic i_run,
  output logic o_tc
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LOAD = CW'(N - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= LOAD;
    end else if (!i_run) begin
      r_cnt <= LOAD;
    end else if (ce && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = i_run && ce && (r_cnt == '0);

endmodule

// File: rtl/mem_init_sequencer.sv
// Copies a 2^AW-byte ROM image into external memory after the controller is ready.
// Defining MEM_INIT_VERIFY_EN adds a readback pass and the sticky error output.
//
// state   | meaning
// IDLE    | waiting for ready
// SETTLE  | counting SETTLE ce ticks before the first access
// FETCH   | srcA = addr, ROM byte captured into memD on exit
// WRITE   | write request held until memAck
// NEXT    | advance addr or finish the copy pass
// DONE    | copy complete, bus released; start re-runs the copy
// VFETCH  | readback: capture ROM byte at addr
// VREAD   | readback: read request held until memAck, compare memQ
// VNEXT   | readback: advance addr or finish
module mem_init_sequencer
  import mem_init_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          ready,
  input  logic          start,
  output logic [AW-1:0] srcA,
  input  logic [7:0]    srcQ,
  output logic          memReq,
  output logic          memWe,
  output logic [AW-1:0] memA,
  output logic [7:0]    memD,
  input  logic          memAck,
  input  logic [7:0]    memQ,
  output logic          done,
  output logic          busy
`ifdef MEM_INIT_VERIFY_EN
  , output logic        error
`endif
);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_memd;
  logic          w_settle_tc;
  logic          w_last;
  logic          w_addr_clr;
  logic          w_addr_inc;
  logic          w_memd_ld;
  logic          w_settle_entry;

  assign w_last         = (r_addr == {AW{1'b1}});
  assign w_settle_entry = (w_next == ST_SETTLE) && (r_state != ST_SETTLE);

  ce_delay #(.N(SETTLE)) u_settle (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .i_run (r_state == ST_SETTLE),
    .o_tc  (w_settle_tc)
  );

`ifdef MEM_INIT_VERIFY_EN
  logic r_error;
  logic w_err_set;
`else
  logic w_unused_memq;
  assign w_unused_memq = ^memQ;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_addr_clr = 1'b0;
    w_addr_inc = 1'b0;
    w_memd_ld  = 1'b0;
`ifdef MEM_INIT_VERIFY_EN
    w_err_set  = 1'b0;
`endif
    if (ce) begin
      // Losing ready aborts everything, including a pending ack or a start pulse.
      if (!ready) begin
        w_next     = ST_IDLE;
        w_addr_clr = 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_next     = ST_SETTLE;
            w_addr_clr = 1'b1;
          end
          ST_SETTLE: if (w_settle_tc) w_next = ST_FETCH;
          ST_FETCH: begin
            w_next    = ST_WRITE;
            w_memd_ld = 1'b1;
          end
          ST_WRITE: if (memAck) w_next = ST_NEXT;
          ST_NEXT: begin
            if (w_last) begin
`ifdef MEM_INIT_VERIFY_EN
              w_next     = ST_VFETCH;
              w_addr_clr = 1'b1;
`else
              w_next     = ST_DONE;
`endif
            end else begin
              w_next     = ST_FETCH;
              w_addr_inc = 1'b1;
            end
          end
          ST_DONE: begin
            if (start) begin
              w_next     = ST_SETTLE;
              w_addr_clr = 1'b1;
            end
          end
`ifdef MEM_INIT_VERIFY_EN
          ST_VFETCH: begin
            w_next    = ST_VREAD;
            w_memd_ld = 1'b1;
          end
          ST_VREAD: begin
            if (memAck) begin
              w_next    = ST_VNEXT;
              w_err_set = (memQ != r_memd);
            end
          end
          ST_VNEXT: begin
            if (w_last) begin
              w_next = ST_DONE;
            end else begin
              w_next     = ST_VFETCH;
              w_addr_inc = 1'b1;
            end
          end
`endif
          default: w_next = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_memd <= '0;
    end else begin
      if (w_addr_clr)      r_addr <= '0;
      else if (w_addr_inc) r_addr <= r_addr + 1'b1;
      if (w_memd_ld)       r_memd <= srcQ;
    end
  end

`ifdef MEM_INIT_VERIFY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              r_error <= 1'b0;
    else if (w_settle_entry) r_error <= 1'b0;
    else if (w_err_set)      r_error <= 1'b1;
  end

  assign error  = r_error;
  assign memReq = (r_state == ST_WRITE) || (r_state == ST_VREAD);
`else
  assign memReq = (r_state == ST_WRITE);
`endif

  assign memWe = (r_state == ST_WRITE);
  assign srcA  = r_addr;
  assign memA  = r_addr;
  assign memD  = r_memd;
  assign done  = (r_state == ST_DONE);
  assign busy  = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_mem_init_sequencer.sv
// Self-checking bench for mem_init_sequencer (AW=4, SETTLE=4); exercises the
// readback pass too when MEM_INIT_VERIFY_EN is defined.
module tb_mem_init_sequencer;

  localparam int AW = 4;
  localparam int S  = 4;
  localparam int NB = 1 << AW;
`ifdef MEM_INIT_VERIFY_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ce = 1'b0;
  logic          ready = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] srcA;
  logic [7:0]    srcQ;
  logic          memReq;
  logic          memWe;
  logic [AW-1:0] memA;
  logic [7:0]    memD;
  logic          memAck = 1'b0;
  logic [7:0]    memQ;
  logic          done;
  logic          busy;
`ifdef MEM_INIT_VERIFY_EN
  logic          error;
`endif

  mem_init_sequencer #(.AW(AW), .SETTLE(S)) dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .ready  (ready),
    .start  (start),
    .srcA   (srcA),
    .srcQ   (srcQ),
    .memReq (memReq),
    .memWe  (memWe),
    .memA   (memA),
    .memD   (memD),
    .memAck (memAck),
    .memQ   (memQ),
    .done   (done),
    .busy   (busy)
`ifdef MEM_INIT_VERIFY_EN
    , .error (error)
`endif
  );

  always #5 clock = ~clock;

  logic [7:0] rom [NB];
  logic [7:0] ext [NB];
  int wr_cnt [NB];
  int req_ticks [NB];
  int dly [NB];
  int wr_log [$];
  int ce_pct = 100;
  bit ack_tied = 1'b0;
  int corrupt_addr = -1;
  int wait_cnt = 0;
  int checks = 0;
  int errors = 0;

  bit            prev_pending = 1'b0;
  bit            prev_acked = 1'b0;
  logic [AW-1:0] prev_a;
  logic [7:0]    prev_d;
  logic          prev_we;

  assign srcQ = rom[srcA];
  assign memQ = (int'(memA) == corrupt_addr) ? 8'h00 : ext[memA];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ce and the memory responder change only on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      ce     = (int'($urandom_range(99)) < ce_pct);
      memAck = ack_tied || (memReq && (wait_cnt >= dly[memA]));
    end
  end

  // External memory model plus bus-protocol observer.
  always @(posedge clock) begin
    if (!reset) begin
      prev_pending = 1'b0;
      prev_acked   = 1'b0;
      wait_cnt     = 0;
    end else if (ce) begin
      if (prev_pending)
        check("hold_stable", {memReq, memWe, memA, memD}, {1'b1, prev_we, prev_a, prev_d});
      if (prev_acked)
        check("req_drop_after_ack", memReq, 1'b0);
      if (memReq && memWe && ready) req_ticks[memA]++;
      if (memReq && memWe && memAck && ready) begin
        ext[memA] = memD;
        wr_cnt[memA]++;
        wr_log.push_back(int'(memA));
      end
      prev_pending = memReq && !memAck && ready;
      prev_acked   = memReq && memAck && ready;
      prev_a       = memA;
      prev_d       = memD;
      prev_we      = memWe;
      wait_cnt     = (memReq && !memAck) ? wait_cnt + 1 : 0;
    end
  end

  task automatic wait_ce();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clock);
      seen = ce;
      #1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_ce: no ce tick within budget");
    end
  endtask

  // ticks = ce edges from the triggering edge (edge 0) to the edge that raised done.
  task automatic run_until_done(input int k0, output int ticks);
    int k;
    k     = k0;
    ticks = -1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clock);
      if (ce) k++;
      #1;
      if (done) begin
        ticks = k - 1;
        break;
      end
    end
  endtask

  task automatic wait_write_at(input int a, output bit found);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clock);
      #1;
      found = memReq && memWe && (int'(memA) == a);
    end
  endtask

  task automatic prep();
    for (int a = 0; a < NB; a++) begin
      rom[a]       = 8'($urandom);
      ext[a]       = ~rom[a];
      wr_cnt[a]    = 0;
      req_ticks[a] = 0;
    end
    wr_log.delete();
  endtask

  task automatic check_image(input string tag);
    int bad_data, bad_cnt, bad_order;
    bad_data  = 0;
    bad_cnt   = 0;
    bad_order = 0;
    for (int a = 0; a < NB; a++) begin
      if (ext[a] !== rom[a]) bad_data++;
      if (wr_cnt[a] != 1) bad_cnt++;
    end
    if (wr_log.size() != NB) bad_order = NB;
    else for (int a = 0; a < NB; a++) if (wr_log[a] != a) bad_order++;
    check({tag, "_data"}, bad_data, 0);
    check({tag, "_write_count"}, bad_cnt, 0);
    check({tag, "_write_order"}, bad_order, 0);
  endtask

  task automatic go_idle();
    @(negedge clock);
    ready = 1'b0;
    wait_ce();
    wait_ce();
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  typedef struct {
    int d_addr;
    int d_len;
    int pct;
    bit start_mid;
    int exp_ticks;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int ticks;
    int sum;
    bit found;

    vecs[0] = '{0,  0, 100, 1'b0, S + NPASS * (3 * NB)};
    vecs[1] = '{7,  5, 100, 1'b0, S + NPASS * (3 * NB + 5)};
    vecs[2] = '{7,  5, 60,  1'b1, S + NPASS * (3 * NB + 5)};
    vecs[3] = '{12, 2, 75,  1'b1, S + NPASS * (3 * NB + 2)};
    vecs[4] = '{15, 1, 50,  1'b0, S + NPASS * (3 * NB + 1)};

    for (int a = 0; a < NB; a++) dly[a] = 0;
    prep();

    repeat (3) @(negedge clock);
    check("rst_srcA", srcA, 0);
    check("rst_memA", memA, 0);
    check("rst_memD", memD, 0);
    check("rst_memReq", memReq, 0);
    check("rst_memWe", memWe, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
`ifdef MEM_INIT_VERIFY_EN
    check("rst_error", error, 0);
`endif
    reset = 1'b1;

    start = 1'b1;
    wait_ce();
    start = 1'b0;
    check("start_in_idle_busy", busy, 0);
    check("start_in_idle_done", done, 0);

    for (int v = 0; v < 5; v++) begin
      prep();
      for (int a = 0; a < NB; a++) dly[a] = 0;
      dly[vecs[v].d_addr] = vecs[v].d_len;
      ack_tied = (vecs[v].d_len == 0);
      ce_pct   = vecs[v].pct;
      @(negedge clock);
      ready = 1'b1;
      fork
        run_until_done(0, ticks);
        if (vecs[v].start_mid) begin
          repeat (25) @(negedge clock);
          start = 1'b1;
          wait_ce();
          start = 1'b0;
        end
      join
      check($sformatf("vec%0d_ticks", v), ticks, vecs[v].exp_ticks);
      check($sformatf("vec%0d_done_busy", v), {done, busy, memReq}, 3'b100);
      check($sformatf("vec%0d_hold_ticks", v), req_ticks[vecs[v].d_addr], 1 + vecs[v].d_len);
      check_image($sformatf("vec%0d", v));
`ifdef MEM_INIT_VERIFY_EN
      check($sformatf("vec%0d_error", v), error, 0);
`endif
      if (v == 4) begin
        prep();
        for (int a = 0; a < NB; a++) dly[a] = 0;
        @(negedge clock);
        start = 1'b1;
        wait_ce();
        start = 1'b0;
        check("restart_done_cleared", done, 0);
        check("restart_busy", busy, 1);
        run_until_done(1, ticks);
        check("restart_ticks", ticks, S + NPASS * 3 * NB);
        check_image("restart");
      end
      go_idle();
    end

    // Random ROM, ce density and per-address ack latency against the cost model.
    for (int r = 0; r < 3; r++) begin
      prep();
      ack_tied = 1'b0;
      ce_pct   = 40 + int'($urandom_range(60));
      sum      = 0;
      for (int a = 0; a < NB; a++) begin
        dly[a] = int'($urandom_range(3));
        sum += 3 + dly[a];
      end
      @(negedge clock);
      ready = 1'b1;
      run_until_done(0, ticks);
      check($sformatf("rand%0d_ticks", r), ticks, S + NPASS * sum);
      check_image($sformatf("rand%0d", r));
      go_idle();
    end

    // Abort in WRITE at address 9, with a simultaneous start pulse.
    prep();
    for (int a = 0; a < NB; a++) dly[a] = 0;
    dly[9]   = 100000;
    ack_tied = 1'b0;
    ce_pct   = 80;
    @(negedge clock);
    ready = 1'b1;
    wait_write_at(9, found);
    check("abort_reach_addr9", found, 1);
    @(negedge clock);
    ready = 1'b0;
    start = 1'b1;
    wait_ce();
    start = 1'b0;
    check("abort_memReq", memReq, 0);
    check("abort_addr", {srcA, memA}, 0);
    check("abort_busy_done", {busy, done}, 2'b00);
    check("abort_no_write9", wr_cnt[9], 0);
    dly[9] = 0;
    prep();
    @(negedge clock);
    ready = 1'b1;
    run_until_done(0, ticks);
    check("abort_recopy_ticks", ticks, S + NPASS * 3 * NB);
    check_image("abort_recopy");
    go_idle();

    // Asynchronous reset while a write is outstanding.
    prep();
    dly[5] = 50;
    @(negedge clock);
    ready = 1'b1;
    wait_write_at(5, found);
    check("rst_mid_reach_addr5", found, 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_memReq", memReq, 0);
    check("rst_mid_outputs", {memWe, done, busy, srcA, memA, memD}, 0);
    @(negedge clock);
    ready = 1'b0;
    dly[5] = 0;
    @(negedge clock);
    reset = 1'b1;

`ifdef MEM_INIT_VERIFY_EN
    prep();
    rom[3]       = rom[3] | 8'h01;
    ack_tied     = 1'b1;
    ce_pct       = 100;
    corrupt_addr = 3;
    @(negedge clock);
    ready = 1'b1;
    run_until_done(0, ticks);
    check("verify_ticks", ticks, S + 2 * 3 * NB);
    check("verify_error_set", {error, done}, 2'b11);
    corrupt_addr = -1;
    @(negedge clock);
    start = 1'b1;
    wait_ce();
    start = 1'b0;
    check("verify_error_cleared", {error, done}, 2'b00);
    run_until_done(1, ticks);
    check("verify_clean_end", {error, done}, 2'b01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
